// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Two-producer write front end for the register file. Each producer (A, B)
//   hands over write requests via valid/ready into a one-entry buffer. A
//   round-robin arbiter drains one buffer per cycle into a registered write
//   port that feeds the register file directly.
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   a_valid/a_ready/a_address/a_data   producer A request channel
//   b_valid/b_ready/b_address/b_data   producer B request channel
//   write_enable/write_address/write_data_out   registered register-file write port
//   writes_issued                  saturating count of write_enable pulses
//   err_out_of_range               sticky flag: an out-of-range request was dropped
//
// NUM_ADDRESS must be at least 2 so the address is at least one bit wide.

// Per-producer one-entry request buffer.
module regfile_write_arbiter_port #(
  parameter int NUM_ADDRESS = 16,
  parameter int DATA_LENGTH = 32,
  parameter int AW          = $clog2(NUM_ADDRESS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid,
  input  logic [AW-1:0]          address,
  input  logic [DATA_LENGTH-1:0] data,
  input  logic                   grant,
  output logic                   ready,
  output logic                   full,
  output logic [AW-1:0]          buf_address,
  output logic [DATA_LENGTH-1:0] buf_data,
  output logic                   oor_drop
);
  logic accept, in_range;

  // A granted entry leaves this cycle, so the slot can take a new request.
  assign ready  = ~full | grant;
  assign accept = valid & ready;

  // With a power-of-two depth every encodable address is legal.
  if (NUM_ADDRESS == (1 << AW)) begin : g_pow2
    assign in_range = 1'b1;
  end else begin : g_limit
    assign in_range = (address < AW'(NUM_ADDRESS));
  end

  // Out-of-range requests complete the handshake but are never buffered.
  assign oor_drop = accept & ~in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full        <= 1'b0;
      buf_address <= '0;
      buf_data    <= '0;
    end else if (accept && in_range) begin
      full        <= 1'b1;
      buf_address <= address;
      buf_data    <= data;
    end else if (grant) begin
      full        <= 1'b0;
    end
  end
endmodule

module regfile_write_arbiter #(
  parameter  int NUM_ADDRESS = 16,
  parameter  int DATA_LENGTH = 32,
  parameter  int COUNT_WIDTH = 16,
  localparam int AW          = $clog2(NUM_ADDRESS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [AW-1:0]          a_address,
  input  logic [DATA_LENGTH-1:0] a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [AW-1:0]          b_address,
  input  logic [DATA_LENGTH-1:0] b_data,
  output logic                   write_enable,
  output logic [AW-1:0]          write_address,
  output logic [DATA_LENGTH-1:0] write_data_out,
  output logic [COUNT_WIDTH-1:0] writes_issued,
  output logic                   err_out_of_range
);
  localparam int NUM_PORTS = 2;  // index 0 = A, 1 = B

  logic [NUM_PORTS-1:0]                  port_valid, port_ready, port_full;
  logic [NUM_PORTS-1:0]                  port_grant, port_oor;
  logic [NUM_PORTS-1:0][AW-1:0]          port_addr, buf_addr;
  logic [NUM_PORTS-1:0][DATA_LENGTH-1:0] port_data, buf_data;
  logic                                  ptr;  // 0: A has priority, 1: B

  assign port_valid = {b_valid, a_valid};
  assign port_addr  = {b_address, a_address};
  assign port_data  = {b_data, a_data};
  assign a_ready    = port_ready[0];
  assign b_ready    = port_ready[1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    regfile_write_arbiter_port #(
      .NUM_ADDRESS (NUM_ADDRESS),
      .DATA_LENGTH (DATA_LENGTH),
      .AW          (AW)
    ) u_port (
      .clk         (clk),
      .reset       (reset),
      .valid       (port_valid[p]),
      .address     (port_addr[p]),
      .data        (port_data[p]),
      .grant       (port_grant[p]),
      .ready       (port_ready[p]),
      .full        (port_full[p]),
      .buf_address (buf_addr[p]),
      .buf_data    (buf_data[p]),
      .oor_drop    (port_oor[p])
    );
  end

  // Grant looks only at buffered state, keeping valid off the ready path.
  always_comb begin
    port_grant = '0;
    case (port_full)
      2'b01:   port_grant = 2'b01;
      2'b10:   port_grant = 2'b10;
      2'b11:   port_grant = ptr ? 2'b10 : 2'b01;
      default: port_grant = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr              <= 1'b0;
      write_enable     <= 1'b0;
      write_address    <= '0;
      write_data_out   <= '0;
      writes_issued    <= '0;
      err_out_of_range <= 1'b0;
    end else begin
      write_enable <= |port_grant;
      if (|port_grant) begin
        write_address  <= port_grant[1] ? buf_addr[1] : buf_addr[0];
        write_data_out <= port_grant[1] ? buf_data[1] : buf_data[0];
        // Winner loses priority: granting A hands the pointer to B and vice versa.
        ptr            <= port_grant[0];
        if (writes_issued != {COUNT_WIDTH{1'b1}})
          writes_issued <= writes_issued + COUNT_WIDTH'(1);
      end
      if (|port_oor)
        err_out_of_range <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int NA = 12;
  localparam int DL = 32;
  localparam int CW = 4;
  localparam int AW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0] a_address, b_address, write_address;
  logic [DL-1:0] a_data, b_data, write_data_out;
  logic          write_enable, err_out_of_range;
  logic [CW-1:0] writes_issued;

  regfile_write_arbiter #(.NUM_ADDRESS(NA), .DATA_LENGTH(DL), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_address(a_address), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_address(b_address), .b_data(b_data),
    .write_enable(write_enable), .write_address(write_address),
    .write_data_out(write_data_out), .writes_issued(writes_issued),
    .err_out_of_range(err_out_of_range)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [AW-1:0] addr; logic [DL-1:0] data; } wr_t;
  wr_t           qa[$], qb[$];
  byte           order_q[$];
  logic [DL-1:0] rf [16];
  int            exp_cnt = 0;
  logic          exp_err = 1'b0;

  typedef struct {
    logic av; logic [AW-1:0] aa; logic [DL-1:0] ad;
    logic bv; logic [AW-1:0] ba; logic [DL-1:0] bd;
    logic we; logic [AW-1:0] wa; logic [DL-1:0] wd;
    logic ar; logic br; int cnt;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted in-range requests queue per port; each observed write
  // must be the head of one of the queues. Count and error flag are modelled too.
  always @(negedge clk) begin
    if (!reset) begin
      if (write_enable) begin
        n_checks++;
        if (qa.size() > 0 && write_address == qa[0].addr && write_data_out == qa[0].data) begin
          void'(qa.pop_front());
          order_q.push_back(8'h41);
        end else if (qb.size() > 0 && write_address == qb[0].addr && write_data_out == qb[0].data) begin
          void'(qb.pop_front());
          order_q.push_back(8'h42);
        end else begin
          n_fail++;
          $display("FAIL sb_write: got addr %0d data %0h, expected a pending request",
                   write_address, write_data_out);
        end
        rf[write_address] = write_data_out;
        if (exp_cnt < CMAX) exp_cnt++;
      end
      chk("sb_count", 64'(writes_issued), 64'(exp_cnt));
      chk("sb_err", 64'(err_out_of_range), 64'(exp_err));
      if (a_valid && a_ready) begin
        if (a_address < NA) qa.push_back('{a_address, a_data});
        else exp_err = 1'b1;
      end
      if (b_valid && b_ready) begin
        if (b_address < NA) qb.push_back('{b_address, b_data});
        else exp_err = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_address = '0; a_data = '0;
    b_valid = 1'b0; b_address = '0; b_data = '0;
  endtask

  task automatic drive_a(input logic [AW-1:0] ad, input logic [DL-1:0] d);
    a_valid = 1'b1; a_address = ad; a_data = d;
  endtask

  task automatic drive_b(input logic [AW-1:0] ad, input logic [DL-1:0] d);
    b_valid = 1'b1; b_address = ad; b_data = d;
  endtask

  task automatic clear_model();
    qa.delete(); qb.delete(); order_q.delete();
    exp_cnt = 0; exp_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    clear_model();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1, 0, 'hA0, 1, 1, 'hB1, 0, 0, 0,     1, 0, 0};
    tbl[1] = '{1, 2, 'hA2, 1, 3, 'hB3, 1, 0, 'hA0, 0, 1, 1};
    tbl[2] = '{1, 4, 'hA4, 1, 3, 'hB3, 1, 1, 'hB1, 1, 0, 2};
    tbl[3] = '{1, 4, 'hA4, 1, 5, 'hB5, 1, 2, 'hA2, 0, 1, 3};
    tbl[4] = '{1, 6, 'hA6, 1, 5, 'hB5, 1, 3, 'hB3, 1, 0, 4};
    tbl[5] = '{1, 6, 'hA6, 1, 7, 'hB7, 1, 4, 'hA4, 0, 1, 5};
    tbl[6] = '{0, 0, 0,    1, 7, 'hB7, 1, 5, 'hB5, 1, 0, 6};
    tbl[7] = '{0, 0, 0,    0, 0, 0,    1, 6, 'hA6, 1, 1, 7};
    tbl[8] = '{0, 0, 0,    0, 0, 0,    1, 7, 'hB7, 1, 1, 8};
    tbl[9] = '{0, 0, 0,    0, 0, 0,    0, 7, 'hB7, 1, 1, 8};

    for (int i = 0; i < 16; i++) rf[i] = '0;
    idle_inputs();
    do_reset();

    // Reset / idle state
    chk("rst_a_ready", 64'(a_ready), 1);
    chk("rst_b_ready", 64'(b_ready), 1);
    chk("rst_we", 64'(write_enable), 0);
    chk("rst_addr", 64'(write_address), 0);
    chk("rst_data", 64'(write_data_out), 0);
    chk("rst_count", 64'(writes_issued), 0);
    chk("rst_err", 64'(err_out_of_range), 0);

    // Single request on A: two-edge latency to write_enable
    drive_a(4'd3, 32'hDEADBEEF);
    tick();
    idle_inputs();
    chk("a_only_we_e1", 64'(write_enable), 0);
    tick();
    chk("a_only_we_e2", 64'(write_enable), 1);
    chk("a_only_addr", 64'(write_address), 3);
    chk("a_only_data", 64'(write_data_out), 64'h0000_0000_DEAD_BEEF);
    chk("a_only_count", 64'(writes_issued), 1);
    tick();
    chk("a_only_we_e3", 64'(write_enable), 0);

    // Contention table: both ports pushing from reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a_valid = tbl[i].av; a_address = tbl[i].aa; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_address = tbl[i].ba; b_data = tbl[i].bd;
      tick();
      chk($sformatf("tbl%0d_we", i), 64'(write_enable), 64'(tbl[i].we));
      chk($sformatf("tbl%0d_addr", i), 64'(write_address), 64'(tbl[i].wa));
      chk($sformatf("tbl%0d_data", i), 64'(write_data_out), 64'(tbl[i].wd));
      chk($sformatf("tbl%0d_a_ready", i), 64'(a_ready), 64'(tbl[i].ar));
      chk($sformatf("tbl%0d_b_ready", i), 64'(b_ready), 64'(tbl[i].br));
      chk($sformatf("tbl%0d_count", i), 64'(writes_issued), 64'(tbl[i].cnt));
    end
    idle_inputs();
    tick();
    chk("order_len", 64'(order_q.size()), 8);
    for (int k = 0; k < order_q.size(); k++)
      chk($sformatf("order%0d", k), 64'(order_q[k]), (k % 2) ? 64'h42 : 64'h41);

    // Same address from both ports in one cycle, pointer at A
    do_reset();
    drive_a(4'd5, 32'h11);
    drive_b(4'd5, 32'h22);
    tick();
    idle_inputs();
    chk("same_we_e1", 64'(write_enable), 0);
    tick();
    chk("same_first_data", 64'(write_data_out), 64'h11);
    tick();
    chk("same_second_we", 64'(write_enable), 1);
    chk("same_second_data", 64'(write_data_out), 64'h22);
    tick();
    chk("same_rf5", 64'(rf[5]), 64'h22);

    // Out-of-range request on A (depth 12, address 13)
    do_reset();
    drive_a(4'd13, 32'h99);
    chk("oor_ready", 64'(a_ready), 1);
    tick();
    idle_inputs();
    chk("oor_err", 64'(err_out_of_range), 1);
    chk("oor_no_we_e1", 64'(write_enable), 0);
    tick();
    chk("oor_no_we_e2", 64'(write_enable), 0);
    chk("oor_ready_after", 64'(a_ready), 1);
    drive_a(4'd2, 32'h77);
    tick();
    idle_inputs();
    tick();
    chk("oor_next_we", 64'(write_enable), 1);
    chk("oor_next_addr", 64'(write_address), 2);
    chk("oor_err_sticky", 64'(err_out_of_range), 1);
    tick();
    chk("oor_err_sticky2", 64'(err_out_of_range), 1);

    // Reset while both buffers are full and a write is on the port
    do_reset();
    drive_a(4'd1, 32'hA1);
    drive_b(4'd2, 32'hB2);
    tick();
    drive_a(4'd3, 32'hA3);
    drive_b(4'd4, 32'hB4);
    tick();
    chk("busy_we_pre", 64'(write_enable), 1);
    reset = 1'b1;
    idle_inputs();
    #1;
    clear_model();
    chk("busy_rst_we", 64'(write_enable), 0);
    chk("busy_rst_addr", 64'(write_address), 0);
    chk("busy_rst_data", 64'(write_data_out), 0);
    chk("busy_rst_count", 64'(writes_issued), 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("busy_post_we%0d", i), 64'(write_enable), 0);
    end
    chk("busy_post_a_ready", 64'(a_ready), 1);
    chk("busy_post_b_ready", 64'(b_ready), 1);

    // Counter saturation: 20 back-to-back writes on A with a 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive_a(AW'(i % NA), 32'h1000 + 32'(i));
      tick();
    end
    idle_inputs();
    tick();
    tick();
    chk("sat_count", 64'(writes_issued), 64'(CMAX));
    chk("sat_drained_a", 64'(qa.size()), 0);
    chk("sat_drained_b", 64'(qb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
